// File: rtl/mesh_input_requester.sv
// Router input-port requester: FIFO-buffered flits, XY route of the head flit, one-hot request held until granted.
// Define MESH_INPUT_REQUESTER_STALL_CNT_EN to add the stall_cycles / starved outputs.
module mesh_input_requester #(
    parameter int DATA_W  = 16,
    parameter int COORD_W = 2,
    parameter int DEPTH   = 4,
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [4:0]        req,
    input  logic [4:0]        gnt,
    output logic [DATA_W-1:0] out_data,
    output logic              out_fire
`ifdef MESH_INPUT_REQUESTER_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic              starved
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]        FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]        ONE_CNT  = (AW+1)'(1);
    localparam logic [COORD_W-1:0] MY_X     = COORD_W'(X_COORD);
    localparam logic [COORD_W-1:0] MY_Y     = COORD_W'(Y_COORD);

    localparam logic [4:0] PORT_LOCAL = 5'b00001;
    localparam logic [4:0] PORT_NORTH = 5'b00010;
    localparam logic [4:0] PORT_EAST  = 5'b00100;
    localparam logic [4:0] PORT_SOUTH = 5'b01000;
    localparam logic [4:0] PORT_WEST  = 5'b10000;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] next_head;
    logic              empty;
    logic              push;
    logic              fire;

    state_t     state;
    state_t     state_next;
    logic [4:0] req_q;
    logic [4:0] req_next;

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic logic [4:0] route(input logic [DATA_W-1:0] flit);
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        dx = flit[COORD_W-1:0];
        dy = flit[2*COORD_W-1:COORD_W];
        if (dx > MY_X)      return PORT_EAST;
        else if (dx < MY_X) return PORT_WEST;
        else if (dy > MY_Y) return PORT_NORTH;
        else if (dy < MY_Y) return PORT_SOUTH;
        else                return PORT_LOCAL;
    endfunction

    assign empty     = (count == '0);
    assign in_ready  = (count != FULL_CNT);
    assign push      = in_valid && in_ready;
    assign fire      = |(req_q & gnt);
    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr + AW'(1)];

    assign req      = req_q;
    assign out_fire = fire;
    assign out_data = empty ? '0 : head;

    // NOTE: the storage array has no reset; stale entries are never visible because
    // out_data is masked when empty and pointers/count are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // sample the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (fire) rd_ptr <= rd_ptr + AW'(1);
            case ({push, fire})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            req_q <= '0;
        end else begin
            state <= state_next;
            req_q <= req_next;
        end
    end

    // NOTE: defaults are assigned before the case so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        req_next   = req_q;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = REQ;
                    req_next   = route(head);
                end
            end
            REQ: begin
                if (fire) begin
                    if (count > ONE_CNT) begin
                        req_next = route(next_head);
                    end else if (push) begin
                        // Pop empties the FIFO; the flit arriving this cycle becomes head.
                        req_next = route(in_data);
                    end else begin
                        state_next = IDLE;
                        req_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = '0;
            end
        endcase
    end

`ifdef MESH_INPUT_REQUESTER_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset || fire) begin
            stall_q <= '0;
        end else if (state == REQ && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign starved      = (stall_q >= 16'd64);
`endif

endmodule

// File: tb/tb_mesh_input_requester.sv
// Directed bench for mesh_input_requester at router (1,1): reset, routing, full/back-to-back, push-on-pop, wrong grant, reset flush.
module tb_mesh_input_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [4:0]  req;
    logic [4:0]  gnt;
    logic [15:0] out_data;
    logic        out_fire;
`ifdef MESH_INPUT_REQUESTER_STALL_CNT_EN
    logic [15:0] stall_cycles;
    logic        starved;
`endif

    int checks   = 0;
    int failures = 0;

    mesh_input_requester #(
        .DATA_W (16),
        .COORD_W(2),
        .DEPTH  (4),
        .X_COORD(1),
        .Y_COORD(1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .req     (req),
        .gnt     (gnt),
        .out_data(out_data),
        .out_fire(out_fire)
`ifdef MESH_INPUT_REQUESTER_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .starved     (starved)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Push one flit into an idle, empty requester, grant it, and confirm it leaves.
    task automatic send_one(input string tag, input logic [15:0] flit, input logic [4:0] exp_req);
        in_valid = 1'b1;
        in_data  = flit;
        tick();
        in_valid = 1'b0;
        tick();
        check({tag, "_req"}, 32'(req), 32'(exp_req));
        gnt = exp_req;
        settle();
        check({tag, "_fire"}, 32'(out_fire), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(flit));
        tick();
        gnt = 5'b0;
        settle();
        check({tag, "_idle"}, 32'(req), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        gnt      = '0;
        tick();
        tick();
        reset = 1'b0;
        settle();

        // Reset state.
        check("rst_req",      32'(req),      32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_fire", 32'(out_fire), 32'd0);

        // 0x0003 -> EAST; request appears one edge after the push edge.
        in_valid = 1'b1;
        in_data  = 16'h0003;
        tick();
        in_valid = 1'b0;
        settle();
        check("lat_req_early", 32'(req), 32'd0);
        tick();
        check("lat_req_east",  32'(req),      32'b00100);
        check("lat_head",      32'(out_data), 32'h0003);
        repeat (5) tick();
        check("hold_req",      32'(req),      32'b00100);
        check("hold_no_fire",  32'(out_fire), 32'd0);
        gnt = 5'b00100;
        settle();
        check("east_fire",     32'(out_fire), 32'd1);
        check("east_data",     32'(out_data), 32'h0003);
        tick();
        gnt = 5'b0;
        settle();
        check("east_idle_req", 32'(req),      32'd0);
        check("east_empty",    32'(out_data), 32'd0);
        check("east_in_ready", 32'(in_ready), 32'd1);

        // Route coverage.
        send_one("local", 16'h0005, 5'b00001);
        send_one("north", 16'h0009, 5'b00010);
        send_one("south", 16'h0001, 5'b01000);
        send_one("west",  16'h0004, 5'b10000);

        // Fill the FIFO, then drain back-to-back with all grants asserted.
        in_valid = 1'b1;
        in_data  = 16'h0003; tick();
        in_data  = 16'h0009; tick();
        in_data  = 16'h0004; tick();
        in_data  = 16'h0005; tick();
        in_valid = 1'b0;
        settle();
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_req",      32'(req),      32'b00100);
        gnt = 5'b11111;
        settle();
        check("b2b_fire0", 32'(out_fire), 32'd1);
        check("b2b_data0", 32'(out_data), 32'h0003);
        tick();
        check("b2b_req1",  32'(req),      32'b00010);
        check("b2b_data1", 32'(out_data), 32'h0009);
        check("b2b_fire1", 32'(out_fire), 32'd1);
        check("b2b_ready", 32'(in_ready), 32'd1);
        tick();
        check("b2b_req2",  32'(req),      32'b10000);
        check("b2b_data2", 32'(out_data), 32'h0004);
        tick();
        check("b2b_req3",  32'(req),      32'b00001);
        check("b2b_data3", 32'(out_data), 32'h0005);
        check("b2b_fire3", 32'(out_fire), 32'd1);
        tick();
        check("b2b_idle",  32'(req),      32'd0);
        check("b2b_nofire", 32'(out_fire), 32'd0);
        gnt = 5'b0;

        // Push on the grant cycle with a single flit queued: no idle bubble.
        in_valid = 1'b1;
        in_data  = 16'h0003;
        tick();
        in_valid = 1'b0;
        tick();
        check("pp_req_east", 32'(req), 32'b00100);
        gnt      = 5'b00100;
        in_valid = 1'b1;
        in_data  = 16'h0001;
        settle();
        check("pp_fire", 32'(out_fire), 32'd1);
        tick();
        gnt      = 5'b0;
        in_valid = 1'b0;
        settle();
        check("pp_req_south", 32'(req),      32'b01000);
        check("pp_data",      32'(out_data), 32'h0001);
        gnt = 5'b01000;
        tick();
        gnt = 5'b0;
        settle();
        check("pp_idle", 32'(req), 32'd0);

        // Wrong grant is ignored; second flit pushed meanwhile.
        in_valid = 1'b1;
        in_data  = 16'h0003;
        tick();
        in_valid = 1'b0;
        tick();
        gnt      = 5'b00010;
        in_valid = 1'b1;
        in_data  = 16'h0009;
        settle();
        check("wg_no_fire", 32'(out_fire), 32'd0);
        tick();
        in_valid = 1'b0;
        settle();
        check("wg_req_held", 32'(req),      32'b00100);
        check("wg_no_pop",   32'(out_data), 32'h0003);
        gnt = 5'b0;

        // Reset with two flits queued flushes everything.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("mrst_req",      32'(req),      32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_out_data", 32'(out_data), 32'd0);
        tick();
        check("mrst_stay_idle", 32'(req), 32'd0);

`ifdef MESH_INPUT_REQUESTER_STALL_CNT_EN
        in_valid = 1'b1;
        in_data  = 16'h0003;
        tick();
        in_valid = 1'b0;
        tick();
        check("stall_start", 32'(stall_cycles), 32'd0);
        repeat (63) tick();
        check("stall_63",    32'(stall_cycles), 32'd63);
        check("starved_63",  32'(starved),      32'd0);
        tick();
        check("starved_64",  32'(starved),      32'd1);
        repeat (6) tick();
        check("stall_70",    32'(stall_cycles), 32'd70);
        check("starved_70",  32'(starved),      32'd1);
        gnt = 5'b00100;
        tick();
        gnt = 5'b0;
        settle();
        check("stall_clear",   32'(stall_cycles), 32'd0);
        check("starved_clear", 32'(starved),      32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
